// File: rtl/theremin_sensor.sv
// theremin_sensor: dual-channel period meter for the theremin front end.
//
// Each channel measures the period of an asynchronous square wave in CLK
// cycles (optionally spanning 2^N input periods) and smooths it with a
// first-order IIR low-pass, acc += (sample_ext - acc) >>> K.
//
// Ports:
//   CLK            in   system clock
//   RESET          in   asynchronous active-low reset (release synchronized)
//   PITCH_FREQ_IN  in   pitch oscillator square wave (async to CLK)
//   VOLUME_FREQ_IN in   volume oscillator square wave (async to CLK)
//   PITCH_PERIOD   out  filtered pitch period, PITCH_OUTPUT_BITS wide
//   VOLUME_PERIOD  out  filtered volume period, VOLUME_OUTPUT_BITS wide

// One measurement-plus-filter path.
//   clk    in   system clock
//   rst_n  in   active-low reset, async assert / sync release
//   freq   in   raw oscillator input
//   period out  top OUTPUT_BITS of the filter accumulator
module theremin_channel #(
    parameter int COUNTER_BITS      = 12,
    parameter int OVERSAMPLING_BITS = 0,
    parameter int FILTER_K_SHIFT    = 2,
    parameter int OUTPUT_BITS       = 32,
    parameter int INTERNAL_BITS     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   freq,
    output logic [OUTPUT_BITS-1:0] period
);
    localparam int M     = COUNTER_BITS + OVERSAMPLING_BITS;
    localparam int GW    = (OVERSAMPLING_BITS > 0) ? OVERSAMPLING_BITS : 1;
    localparam int SHIFT = INTERNAL_BITS - M;

    logic [2:0]                    sync;       // [0],[1] synchronizer, [2] edge history
    logic                          rise;
    logic [GW-1:0]                 grp;        // rising edges seen, modulo 2^N
    logic                          sel;
    logic [M-1:0]                  cnt;
    logic                          armed;
    logic [M-1:0]                  sample;
    logic                          sample_vld;
    logic [INTERNAL_BITS-1:0]      acc;
    logic [INTERNAL_BITS-1:0]      sample_ext;
    logic signed [INTERNAL_BITS:0] delta;
    logic [INTERNAL_BITS-1:0]      step;

    assign rise = sync[1] & ~sync[2];
    // grp is pinned at zero when N=0, so every edge is selected.
    assign sel  = rise && (grp == '0);

    // Counter restarts at 1 on the selected edge: the edge cycle itself is
    // the first cycle of the next period, so an exact period P reads as P.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync       <= '0;
            grp        <= '0;
            cnt        <= '0;
            armed      <= 1'b0;
            sample     <= '0;
            sample_vld <= 1'b0;
        end else begin
            sync       <= {sync[1:0], freq};
            sample_vld <= 1'b0;
            if (rise)
                grp <= (OVERSAMPLING_BITS == 0) ? '0 : grp + GW'(1);
            if (sel) begin
                cnt   <= M'(1);
                armed <= 1'b1;
                if (armed) begin
                    sample     <= cnt;
                    sample_vld <= 1'b1;
                end
            end else if (cnt != '1) begin
                cnt <= cnt + M'(1);
            end
        end
    end

    // Sample is left-aligned so the accumulator is a fraction of full scale.
    assign sample_ext = INTERNAL_BITS'(sample) << SHIFT;
    assign delta      = $signed({1'b0, sample_ext}) - $signed({1'b0, acc});
    // The true sum always lands in [0, 2^I), so modular I-bit addition of the
    // floored step is exact.
    assign step       = INTERNAL_BITS'(delta >>> FILTER_K_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (sample_vld)
            acc <= acc + step;
    end

    assign period = acc[INTERNAL_BITS-1 -: OUTPUT_BITS];
endmodule

module theremin_sensor #(
    parameter int PITCH_COUNTER_BITS       = 12,
    parameter int PITCH_OVERSAMPLING_BITS  = 0,
    parameter int PITCH_FILTER_K_SHIFT     = 2,
    parameter int PITCH_OUTPUT_BITS        = 32,
    parameter int PITCH_INTERNAL_BITS      = 32,
    parameter int VOLUME_COUNTER_BITS      = 12,
    parameter int VOLUME_OVERSAMPLING_BITS = 0,
    parameter int VOLUME_FILTER_K_SHIFT    = 2,
    parameter int VOLUME_OUTPUT_BITS       = 32,
    parameter int VOLUME_INTERNAL_BITS     = 32
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          PITCH_FREQ_IN,
    input  logic                          VOLUME_FREQ_IN,
    output logic [PITCH_OUTPUT_BITS-1:0]  PITCH_PERIOD,
    output logic [VOLUME_OUTPUT_BITS-1:0] VOLUME_PERIOD
);
    // Asserts immediately, releases two clocks after RESET rises.
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            rst_pipe <= '0;
        else
            rst_pipe <= {rst_pipe[0], 1'b1};
    end

    assign rst_n = rst_pipe[1];

    theremin_channel #(
        .COUNTER_BITS      (PITCH_COUNTER_BITS),
        .OVERSAMPLING_BITS (PITCH_OVERSAMPLING_BITS),
        .FILTER_K_SHIFT    (PITCH_FILTER_K_SHIFT),
        .OUTPUT_BITS       (PITCH_OUTPUT_BITS),
        .INTERNAL_BITS     (PITCH_INTERNAL_BITS)
    ) u_pitch (
        .clk    (CLK),
        .rst_n  (rst_n),
        .freq   (PITCH_FREQ_IN),
        .period (PITCH_PERIOD)
    );

    theremin_channel #(
        .COUNTER_BITS      (VOLUME_COUNTER_BITS),
        .OVERSAMPLING_BITS (VOLUME_OVERSAMPLING_BITS),
        .FILTER_K_SHIFT    (VOLUME_FILTER_K_SHIFT),
        .OUTPUT_BITS       (VOLUME_OUTPUT_BITS),
        .INTERNAL_BITS     (VOLUME_INTERNAL_BITS)
    ) u_volume (
        .clk    (CLK),
        .rst_n  (rst_n),
        .freq   (VOLUME_FREQ_IN),
        .period (VOLUME_PERIOD)
    );
endmodule

// File: tb/tb_theremin_sensor.sv
// tb_theremin_sensor: bench for theremin_sensor.
// Two instances share the inputs: dut_def (all defaults) and dut_k0
// (pitch K=0; volume N=1, K=0, 16-bit output). A reference model computes
// each channel's period from the times of sampled rising edges and the
// IIR rule, then publishes the result 3 cycles after the edge is sampled.
module tb_theremin_sensor;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        pin_r = 1'b0;
    logic        vol_r = 1'b0;
    logic [31:0] p_def, v_def, p_k0;
    logic [15:0] v_k0;

    always #5 CLK = ~CLK;

    theremin_sensor dut_def (
        .CLK(CLK), .RESET(RESET), .PITCH_FREQ_IN(pin_r), .VOLUME_FREQ_IN(vol_r),
        .PITCH_PERIOD(p_def), .VOLUME_PERIOD(v_def)
    );

    theremin_sensor #(
        .PITCH_FILTER_K_SHIFT(0), .VOLUME_OVERSAMPLING_BITS(1),
        .VOLUME_FILTER_K_SHIFT(0), .VOLUME_OUTPUT_BITS(16)
    ) dut_k0 (
        .CLK(CLK), .RESET(RESET), .PITCH_FREQ_IN(pin_r), .VOLUME_FREQ_IN(vol_r),
        .PITCH_PERIOD(p_k0), .VOLUME_PERIOD(v_k0)
    );

    int tests = 0;
    int fails = 0;

    // model index m = instance*2 + channel (channel 0 pitch, 1 volume)
    int     pN[4] = '{0, 0, 0, 1};
    int     pK[4] = '{2, 2, 0, 0};
    int     pM[4] = '{12, 12, 12, 13};
    int     pO[4] = '{32, 32, 32, 16};
    longint acc[4], last[4], vis[4];
    int     ecnt[4];
    bit     armed[4];
    bit     prev[2];
    longint cyc = 0;

    typedef struct {
        longint due;
        int     m;
        longint val;
    } upd_t;
    upd_t q[$];

    logic [111:0] obs_w, exp_w;
    assign obs_w = {p_def, v_def, p_k0, v_k0};
    assign exp_w = {vis[0][31:0], vis[1][31:0], vis[2][31:0], vis[3][15:0]};

    // Reference model, advanced on every rising clock edge.
    initial begin
        bit     lvl[2];
        longint s, ext, dl, smax;
        int     m;
        for (int i = 0; i < 4; i++) begin
            acc[i] = 0; last[i] = 0; vis[i] = 0; ecnt[i] = 0; armed[i] = 0;
        end
        prev[0] = 0; prev[1] = 0;
        forever begin
            @(posedge CLK);
            cyc++;
            if (!RESET) begin
                for (int i = 0; i < 4; i++) begin
                    acc[i] = 0; vis[i] = 0; ecnt[i] = 0; armed[i] = 0;
                end
                q.delete();
                prev[0] = 0; prev[1] = 0;
            end else begin
                lvl[0] = pin_r;
                lvl[1] = vol_r;
                for (int ch = 0; ch < 2; ch++) begin
                    if (lvl[ch] && !prev[ch]) begin
                        for (int d = 0; d < 2; d++) begin
                            m = d * 2 + ch;
                            if (ecnt[m] % (1 << pN[m]) == 0) begin
                                if (armed[m]) begin
                                    smax = (64'sd1 <<< pM[m]) - 1;
                                    s    = cyc - last[m];
                                    if (s > smax) s = smax;
                                    ext    = s <<< (32 - pM[m]);
                                    dl     = ext - acc[m];
                                    acc[m] = acc[m] + (dl >>> pK[m]);
                                    q.push_back('{cyc + 3, m, acc[m] >>> (32 - pO[m])});
                                end
                                armed[m] = 1;
                                last[m]  = cyc;
                            end
                            ecnt[m]++;
                        end
                    end
                end
                prev[0] = lvl[0];
                prev[1] = lvl[1];
            end
            while (q.size() > 0 && q[0].due <= cyc) begin
                vis[q[0].m] = q[0].val;
                void'(q.pop_front());
            end
        end
    end

    // Square wave generator; call at a negedge. Rises immediately, so
    // back-to-back calls keep exact periods.
    task automatic drive_ch(input int ch, input int lo, input int hi, input int edges);
        int p, h;
        for (int e = 0; e < edges; e++) begin
            p = $urandom_range(hi, lo);
            h = $urandom_range(p - 2, 2);
            if (ch == 0) pin_r = 1'b1; else vol_r = 1'b1;
            repeat (h) @(negedge CLK);
            if (ch == 0) pin_r = 1'b0; else vol_r = 1'b0;
            repeat (p - h) @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (i % 3 == 0) pin_r = ~pin_r;
            if (i % 4 == 0) vol_r = ~vol_r;
            tests++;
            if (obs_w !== 112'h0) begin
                fails++;
                $display("FAIL reset_hold got=%h want=0", obs_w);
            end
        end
        pin_r = 0; vol_r = 0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        repeat (8) begin
            @(negedge CLK);
            tests++;
            if (obs_w !== 112'h0) begin
                fails++;
                $display("FAIL reset_release got=%h want=0", obs_w);
            end
        end
    endtask

    // Two hand-placed edges 269 apart; ends at the negedge of the third rise.
    task automatic test_first_update();
        pin_r = 1;
        repeat (100) @(negedge CLK);
        pin_r = 0;
        repeat (169) @(negedge CLK);
        pin_r = 1;
        repeat (4) @(negedge CLK);
        tests++;
        if (p_def !== 32'h04340000) begin
            fails++;
            $display("FAIL first_update_def got=%h want=04340000", p_def);
        end
        tests++;
        if (p_k0 !== 32'h10D00000) begin
            fails++;
            $display("FAIL first_update_k0 got=%h want=10D00000", p_k0);
        end
        tests++;
        if (obs_w !== exp_w) begin
            fails++;
            $display("FAIL first_update_model got=%h want=%h", obs_w, exp_w);
        end
        repeat (96) @(negedge CLK);
        pin_r = 0;
        repeat (169) @(negedge CLK);
    endtask

    task automatic test_steady();
        bit dp = 0, dv = 0;
        int g = 0;
        fork
            begin drive_ch(0, 269, 269, 80); dp = 1; end
            begin drive_ch(1, 647, 647, 34); dv = 1; end
            begin
                while (!(dp && dv) && g < 40000) begin
                    @(negedge CLK);
                    g++;
                    tests++;
                    if (obs_w !== exp_w) begin
                        fails++;
                        if (fails < 20) $display("FAIL steady got=%h want=%h", obs_w, exp_w);
                    end
                end
            end
        join
        if (g >= 40000) begin
            fails++;
            $display("FAIL steady_timeout got=%0d want<40000", g);
        end
        tests++;
        if (p_k0 !== 32'h10D00000) begin
            fails++;
            $display("FAIL steady_k0_pitch got=%h want=10D00000", p_k0);
        end
        tests++;
        if (v_k0 !== 16'h2870) begin
            fails++;
            $display("FAIL steady_k0_vol_n1 got=%h want=2870", v_k0);
        end
        tests++;
        if (p_def > 32'h10D00000 || p_def < 32'h10D00000 - 3) begin
            fails++;
            $display("FAIL steady_def_settle got=%h want=10CFFFFD..10D00000", p_def);
        end
    endtask

    task automatic test_step();
        bit     dp = 0;
        int     g = 0;
        longint err;
        fork
            begin drive_ch(0, 537, 537, 20); dp = 1; end
            begin
                while (!dp && g < 20000) begin
                    @(negedge CLK);
                    g++;
                    tests++;
                    if (obs_w !== exp_w) begin
                        fails++;
                        if (fails < 20) $display("FAIL step got=%h want=%h", obs_w, exp_w);
                    end
                end
            end
        join
        if (g >= 20000) begin
            fails++;
            $display("FAIL step_timeout got=%0d want<20000", g);
        end
        err = 64'h21900000 - longint'(p_def);
        if (err < 0) err = -err;
        tests++;
        if (err > 64'h21900000 / 100) begin
            fails++;
            $display("FAIL step_within_1pct got=%h want~21900000", p_def);
        end
        tests++;
        if (p_k0 !== 32'h21900000) begin
            fails++;
            $display("FAIL step_k0 got=%h want=21900000", p_k0);
        end
    endtask

    // Called at the negedge exactly 537 cycles after the last step edge.
    task automatic test_saturation();
        pin_r = 1;
        for (int i = 0; i < 5003; i++) begin
            @(negedge CLK);
            if (i == 2) pin_r = 0;
            tests++;
            if (obs_w !== exp_w) begin
                fails++;
                if (fails < 20) $display("FAIL sat_hold got=%h want=%h", obs_w, exp_w);
            end
            if (i == 2500) begin
                tests++;
                if (p_k0 !== 32'h21900000) begin
                    fails++;
                    $display("FAIL sat_hold_k0 got=%h want=21900000", p_k0);
                end
            end
        end
        pin_r = 1;
        repeat (4) @(negedge CLK);
        tests++;
        if (p_k0 !== 32'hFFF00000) begin
            fails++;
            $display("FAIL sat_k0 got=%h want=FFF00000", p_k0);
        end
        tests++;
        if (obs_w !== exp_w) begin
            fails++;
            $display("FAIL sat_model got=%h want=%h", obs_w, exp_w);
        end
        repeat (3) @(negedge CLK);
        pin_r = 0;
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_random(input int edges);
        bit dp = 0, dv = 0;
        int g = 0;
        fork
            begin drive_ch(0, 4, 200, edges); dp = 1; end
            begin drive_ch(1, 4, 200, edges); dv = 1; end
            begin
                while (!(dp && dv) && g < 30000) begin
                    @(negedge CLK);
                    g++;
                    tests++;
                    if (obs_w !== exp_w) begin
                        fails++;
                        if (fails < 20) $display("FAIL random got=%h want=%h", obs_w, exp_w);
                    end
                end
            end
        join
        if (g >= 30000) begin
            fails++;
            $display("FAIL random_timeout got=%0d want<30000", g);
        end
    endtask

    task automatic test_reset_midrun();
        bit dp = 0, dv = 0;
        int g = 0;
        test_random(40);
        #3 RESET = 1'b0;
        #1;
        tests++;
        if (obs_w !== 112'h0) begin
            fails++;
            $display("FAIL midrun_reset got=%h want=0", obs_w);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (i % 3 == 0) pin_r = ~pin_r;
            vol_r = ~vol_r;
            tests++;
            if (obs_w !== 112'h0) begin
                fails++;
                $display("FAIL midrun_hold got=%h want=0", obs_w);
            end
        end
        pin_r = 0; vol_r = 0;
        @(negedge CLK);
        RESET = 1'b1;
        repeat (6) @(negedge CLK);
        fork
            begin drive_ch(0, 269, 269, 20); dp = 1; end
            begin drive_ch(1, 647, 647, 10); dv = 1; end
            begin
                while (!(dp && dv) && g < 20000) begin
                    @(negedge CLK);
                    g++;
                    tests++;
                    if (obs_w !== exp_w) begin
                        fails++;
                        if (fails < 20) $display("FAIL recovery got=%h want=%h", obs_w, exp_w);
                    end
                end
            end
        join
        if (g >= 20000) begin
            fails++;
            $display("FAIL recovery_timeout got=%0d want<20000", g);
        end
        tests++;
        if (p_k0 !== 32'h10D00000) begin
            fails++;
            $display("FAIL recovery_k0 got=%h want=10D00000", p_k0);
        end
    endtask

    initial begin
        test_reset();
        @(negedge CLK);
        test_first_update();
        test_steady();
        test_step();
        test_saturation();
        test_random(120);
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/theremin_sensor.md
# theremin_sensor

Dual-channel period meter for the theremin front end. It measures the periods of the pitch and volume oscillator square waves in system-clock cycles and smooths each with a first-order IIR low-pass filter. It presents two continuously updated fixed-point period words to the audio/control logic. The two channels are identical, fully independent instances of one measurement-plus-filter path.

## Interface
Parameters (X = PITCH or VOLUME, one set per channel):
- X_COUNTER_BITS, 12: width of the raw period counter.
- X_OVERSAMPLING_BITS, 0: N; one measurement spans 2^N input periods. Legal values 0..3.
- X_FILTER_K_SHIFT, 2: IIR coefficient 2^-K. K=0 means no filtering.
- X_OUTPUT_BITS, 32: output width; must be ≤ X_INTERNAL_BITS.
- X_INTERNAL_BITS, 32: accumulator width; must be ≥ M+1, where M = COUNTER_BITS+OVERSAMPLING_BITS.

Ports:
- CLK  in  1  system clock, 100 MHz nominal.
- RESET  in  1  reset, asynchronous, active-low.
- PITCH_FREQ_IN  in  1  pitch oscillator square wave; asynchronous to CLK.
- VOLUME_FREQ_IN  in  1  volume oscillator square wave; asynchronous to CLK.
- PITCH_PERIOD  out  PITCH_OUTPUT_BITS  filtered pitch period.
- VOLUME_PERIOD  out  VOLUME_OUTPUT_BITS  filtered volume period.

## Operation
Each channel operates as follows:
- **Synchronizer:** two-flop synchronizer, then a third flop for edge detection. A rising edge is detected when sync2=1 and sync3=0. Falling edges are ignored.
- **Counter:** M-bit counter increments every CLK. It saturates at 2^M−1 and never wraps.
- **Edge grouping:** an edge counter selects every 2^N-th detected rising edge; for N=0, every edge is selected.
- **On a selected edge:** the counter value is captured as `sample`, where sample = CLK cycles elapsed since the previous selected edge. The counter then restarts so that an exact input period of P cycles yields sample = P·2^N.
- **First selected edge after reset:** only arms the counter. It produces no sample.
- **Filter:**
  - sample_ext = sample << (INTERNAL_BITS−M).
  - delta = sample_ext − acc, computed signed at INTERNAL_BITS+1 bits.
  - acc ← acc + (delta >>> K), using an arithmetic (floor) shift.
  - acc is unsigned and cannot overflow.
- **Output:** X_PERIOD = acc[INTERNAL_BITS−1 −: OUTPUT_BITS]. It represents the period as a fraction of full counter scale; with defaults, PERIOD = cycles·2^20.
- **No edges:** the output holds its last value. A saturated sample (all ones) is only delivered when an edge eventually arrives.
- **Simultaneous events:** edges on both channels in the same cycle are handled independently.
- **Reset:** asserting RESET at any time clears sync flops, counters, edge counters, armed flags and accumulators. Both outputs read 0.

## Timing
- Outputs are direct register slices; no combinational path from the inputs.
- Latency: the filter update is visible 4 CLK rising edges after the input is first sampled high (2 sync, 1 capture, 1 accumulate).
- Update rate: one acc update per selected edge; acc is unchanged in all other cycles.
- Minimum input high or low time for guaranteed detection: 2 CLK cycles.
- Reset release is synchronized internally; the first edge is detected no earlier than 2 cycles after RESET rises.

## Test plan
- **Reset:** hold RESET=0 with both inputs toggling → PITCH_PERIOD=VOLUME_PERIOD=0x00000000 throughout. Assert RESET mid-run → both outputs are 0 on the next cycle.
- **K=0, steady input:** PITCH_FILTER_K_SHIFT=0, pitch period exactly 269 cycles → PITCH_PERIOD=0x10D00000 from the 2nd edge's update onward, constant.
- **Defaults, steady input:** defaults, pitch 269 cycles → first update 0x04340000, then monotonic rise, settling within 3 LSB below 0x10D00000.
- **Step response:** defaults, pitch step 269→537 cycles → monotonic increase, within 1% of 0x21900000 after ≤16 updates.
- **Saturation:** K=0, pitch held low 5000 cycles, then an edge → PITCH_PERIOD=0xFFF00000. Output is unchanged while no edges arrive.
- **Independence:** pitch 269 and volume 647 cycles, including coincident edges → outputs converge to 0x10D00000 and 0x28700000 respectively.
